// File: rtl/ram_arbitro.sv
// Two-master request/ack arbiter and sequencer for the shared async RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed A-over-B.
module ram_arbitro #(
  parameter int ANCHO_DIR  = 8,
  parameter int ANCHO_DATO = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ANCHO_DIR-1:0]  dir_a,
  input  logic [ANCHO_DIR-1:0]  dir_b,
  input  logic [ANCHO_DATO-1:0] dato_a,
  input  logic [ANCHO_DATO-1:0] dato_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic [ANCHO_DATO-1:0] dato_lect,
  output logic                  ocupado,
  output logic [ANCHO_DIR-1:0]  ram_direccion,
  output logic [ANCHO_DATO-1:0] ram_dato_e,
  output logic                  ram_EN,
  input  logic [ANCHO_DATO-1:0] ram_dato_s
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESO = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] estado;
  logic       ultimo;
  logic       we_l;
  logic       gana_b;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    gana_b = req_b & (~req_a | ~ultimo);
`else
    gana_b = req_b & ~req_a;
`endif
  end

  // Latched address/data double as the RAM bus, so they hold between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado        <= IDLE;
      ultimo        <= 1'b1;
      we_l          <= 1'b0;
      ram_direccion <= '0;
      ram_dato_e    <= '0;
      dato_lect     <= '0;
      ack_a         <= 1'b0;
      ack_b         <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (req_a | req_b) begin
            estado        <= ACCESO;
            ultimo        <= gana_b;
            we_l          <= gana_b ? we_b : we_a;
            ram_direccion <= gana_b ? dir_b : dir_a;
            ram_dato_e    <= gana_b ? dato_b : dato_a;
          end
        end
        ACCESO: begin
          estado <= RESP;
          if (!we_l) dato_lect <= ram_dato_s;
          if (ultimo) ack_b <= 1'b1;
          else        ack_a <= 1'b1;
        end
        RESP: begin
          estado <= IDLE;
          ack_a  <= 1'b0;
          ack_b  <= 1'b0;
        end
        default: estado <= IDLE;
      endcase
    end
  end

  // Decoded from state so reset drops the write strobe without a clock.
  assign ram_EN  = (estado == ACCESO) & we_l;
  assign ocupado = (estado != IDLE);

endmodule
